// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: op encoding, FSM states, offset width.
package mem_pkg;

  localparam int OFFSET_W = 16;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_SW  = 3'd1,
    OP_LB  = 3'd2,
    OP_LBU = 3'd3,
    OP_SB  = 3'd4
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } stage_state_t;

  // Ops that need the current memory word: loads, plus SB for its read-modify-write.
  function automatic logic op_reads(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
  endfunction

  function automatic logic op_word(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane helper: extracts/extends one byte of a word for loads and merges a byte
// into a word for sub-word stores. Purely combinational.
module mem_byte_lane #(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] word_i,
  input  logic [1:0]        byte_sel_i,
  input  logic [7:0]        byte_i,
  input  logic              sign_ext_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] merged_o
);

  logic [7:0] lane;

  always_comb begin
    lane     = word_i[7:0];
    merged_o = word_i;
    case (byte_sel_i)
      2'd0: begin
        lane           = word_i[7:0];
        merged_o[7:0]  = byte_i;
      end
      2'd1: begin
        lane           = word_i[15:8];
        merged_o[15:8] = byte_i;
      end
      2'd2: begin
        lane            = word_i[23:16];
        merged_o[23:16] = byte_i;
      end
      default: begin
        lane            = word_i[31:24];
        merged_o[31:24] = byte_i;
      end
    endcase
    load_o = {{(WORD_W-8){sign_ext_i & lane[7]}}, lane};
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage in front of the versioned data memory: EA compute, vmem strobes,
// sub-word RMW and Finish reporting. Byte ops are built only with MEM_STAGE_BYTE_OPS_EN.
//
//  state   | meaning
//  IDLE    | ready for a new op from the IQ
//  RD      | vm_read_en asserted, read word captured at the edge
//  WR      | vm_write_en asserted with store or merged word
//  DONE    | result/exception on the Finish bus until fin_ready
module mem_stage
  import mem_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int DATA_ADDR_W = 16,
  parameter int IQ_ADDR_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [2:0]                in_op_i,
  input  logic [WORD_W-1:0]         in_base_i,
  input  logic [OFFSET_W-1:0]       in_offset_i,
  input  logic [WORD_W-1:0]         in_sdata_i,
  input  logic [IQ_ADDR_W-1:0]      in_iq_pos_i,
  input  logic [(1<<IQ_ADDR_W)-1:0] flush_mask_i,
  output logic [DATA_ADDR_W-1:0]    vm_addr_o,
  output logic [IQ_ADDR_W-1:0]      vm_iq_pos_o,
  output logic                      vm_read_en_o,
  input  logic [WORD_W-1:0]         vm_rdata_i,
  output logic                      vm_write_en_o,
  output logic [WORD_W-1:0]         vm_wdata_o,
  output logic                      fin_valid_o,
  input  logic                      fin_ready_i,
  output logic [IQ_ADDR_W-1:0]      fin_iq_pos_o,
  output logic [WORD_W-1:0]         fin_data_o,
  output logic                      fin_exc_o
);

  stage_state_t state_q, state_d;

  logic [2:0]             op_q, op_d;
  logic [DATA_ADDR_W+1:0] ea_q, ea_d;
  logic [WORD_W-1:0]      sdata_q, sdata_d;
  logic [IQ_ADDR_W-1:0]   pos_q, pos_d;
  logic                   exc_q, exc_d;
  logic [WORD_W-1:0]      rdata_q, rdata_d;

  logic [WORD_W-1:0] ea_full;
  logic              op_legal;
  logic              range_bad;
  logic              align_bad;
  logic              in_exc;
  logic              accept;
  logic              in_drop;
  logic              flush_now;

  logic [WORD_W-1:0] lane_load;
  logic [WORD_W-1:0] lane_merged;

  // ---------------------------------------------------------------- EA and checks
  always_comb begin
    ea_full   = in_base_i + {{(WORD_W-OFFSET_W){in_offset_i[OFFSET_W-1]}}, in_offset_i};
    range_bad = |ea_full[WORD_W-1:DATA_ADDR_W+2];
    align_bad = op_word(in_op_i) && (ea_full[1:0] != 2'b00);
`ifdef MEM_STAGE_BYTE_OPS_EN
    op_legal  = (in_op_i == OP_LW) || (in_op_i == OP_SW) || (in_op_i == OP_LB) ||
                (in_op_i == OP_LBU) || (in_op_i == OP_SB);
`else
    op_legal  = (in_op_i == OP_LW) || (in_op_i == OP_SW);
`endif
    in_exc    = range_bad || align_bad || !op_legal;
  end

  assign accept    = in_valid_i && in_ready_o;
  assign in_drop   = flush_mask_i[in_iq_pos_i];
  assign flush_now = (state_q != ST_IDLE) && flush_mask_i[pos_q];

  // ---------------------------------------------------------------- operand capture
  always_comb begin
    op_d    = op_q;
    ea_d    = ea_q;
    sdata_d = sdata_q;
    pos_d   = pos_q;
    exc_d   = exc_q;
    rdata_d = rdata_q;
    if (accept) begin
      op_d    = in_op_i;
      ea_d    = ea_full[DATA_ADDR_W+1:0];
      sdata_d = in_sdata_i;
      pos_d   = in_iq_pos_i;
      exc_d   = in_exc;
    end
    if (state_q == ST_RD) begin
      rdata_d = vm_rdata_i;
    end
  end

  mem_byte_lane #(
    .WORD_W (WORD_W)
  ) u_byte_lane (
    .word_i     (rdata_q),
    .byte_sel_i (ea_q[1:0]),
    .byte_i     (sdata_q[7:0]),
    .sign_ext_i (op_q == OP_LB),
    .load_o     (lane_load),
    .merged_o   (lane_merged)
  );

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d       = state_q;
    in_ready_o    = 1'b0;
    vm_read_en_o  = 1'b0;
    vm_write_en_o = 1'b0;
    vm_wdata_o    = '0;
    vm_addr_o     = '0;
    vm_iq_pos_o   = '0;
    fin_valid_o   = 1'b0;
    fin_iq_pos_o  = '0;
    fin_data_o    = '0;
    fin_exc_o     = 1'b0;

    if (state_q != ST_IDLE) begin
      vm_addr_o   = ea_q[DATA_ADDR_W+1:2];
      vm_iq_pos_o = pos_q;
    end

    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (accept && !in_drop) begin
          if (in_exc)                 state_d = ST_DONE;
          else if (op_reads(in_op_i)) state_d = ST_RD;
          else                        state_d = ST_WR;
        end
      end
      ST_RD: begin
        vm_read_en_o = 1'b1;
        if (flush_now)            state_d = ST_IDLE;
        else if (op_q == OP_SB)   state_d = ST_WR;
        else                      state_d = ST_DONE;
      end
      ST_WR: begin
        vm_write_en_o = !flush_now;
        vm_wdata_o    = (op_q == OP_SB) ? lane_merged : sdata_q;
        state_d       = flush_now ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        fin_valid_o  = !flush_now;
        fin_iq_pos_o = pos_q;
        fin_exc_o    = exc_q && !flush_now;
        if (!exc_q) begin
          if (op_q == OP_LW)                          fin_data_o = rdata_q;
          else if ((op_q == OP_LB) || (op_q == OP_LBU)) fin_data_o = lane_load;
        end
        // Flush wins over a simultaneous fin_ready; either way the slot is released.
        if (flush_now || fin_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      ea_q    <= '0;
      sdata_q <= '0;
      pos_q   <= '0;
      exc_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ea_q    <= ea_d;
      sdata_q <= sdata_d;
      pos_q   <= pos_d;
      exc_q   <= exc_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage; byte-op expectations follow MEM_STAGE_BYTE_OPS_EN.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [31:0] in_base = '0;
  logic [15:0] in_offset = '0;
  logic [31:0] in_sdata = '0;
  logic [2:0]  in_iq_pos = '0;
  logic [7:0]  flush_mask = '0;
  logic [15:0] vm_addr;
  logic [2:0]  vm_iq_pos;
  logic        vm_read_en;
  logic [31:0] vm_rdata = '0;
  logic        vm_write_en;
  logic [31:0] vm_wdata;
  logic        fin_valid;
  logic        fin_ready = 1'b1;
  logic [2:0]  fin_iq_pos;
  logic [31:0] fin_data;
  logic        fin_exc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  pos;
    logic [31:0] data;
    logic        exc;
    int          lat;
  } fin_exp_t;

  fin_exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_op_i       (in_op),
    .in_base_i     (in_base),
    .in_offset_i   (in_offset),
    .in_sdata_i    (in_sdata),
    .in_iq_pos_i   (in_iq_pos),
    .flush_mask_i  (flush_mask),
    .vm_addr_o     (vm_addr),
    .vm_iq_pos_o   (vm_iq_pos),
    .vm_read_en_o  (vm_read_en),
    .vm_rdata_i    (vm_rdata),
    .vm_write_en_o (vm_write_en),
    .vm_wdata_o    (vm_wdata),
    .fin_valid_o   (fin_valid),
    .fin_ready_i   (fin_ready),
    .fin_iq_pos_o  (fin_iq_pos),
    .fin_data_o    (fin_data),
    .fin_exc_o     (fin_exc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // flush_cyc: 0 = flush on accept, N>0 = flush during cycle N after accept, 99 = none.
  // hold: number of fin_valid cycles with fin_ready held low.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] base,
                        input logic [15:0] off, input logic [31:0] sdata, input logic [2:0] pos,
                        input logic [31:0] rdata, input int flush_cyc, input int hold);
    logic [31:0] ea, exp_data, exp_wdata;
    logic [7:0]  bsel_byte;
    logic        legal, exc, exp_rd, exp_wr, dropped, flushed, ended;
    logic        rd_seen, wr_seen, fin_seen;
    int          lat, wr_cyc, hold_cnt;
    fin_exp_t    e, got;

    ea    = base + {{16{off[15]}}, off};
    legal = (op == OP_LW) || (op == OP_SW);
`ifdef MEM_STAGE_BYTE_OPS_EN
    legal = legal || (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
`endif
    exc = (ea[31:18] != 0) || (((op == OP_LW) || (op == OP_SW)) && (ea[1:0] != 0)) || !legal;
    bsel_byte = rdata[8*ea[1:0] +: 8];
    exp_data  = 32'h0;
    exp_wdata = sdata;
    if (!exc) begin
      if (op == OP_LW)  exp_data = rdata;
      if (op == OP_LB)  exp_data = {{24{bsel_byte[7]}}, bsel_byte};
      if (op == OP_LBU) exp_data = {24'h0, bsel_byte};
      if (op == OP_SB) begin
        exp_wdata = rdata;
        exp_wdata[8*ea[1:0] +: 8] = sdata[7:0];
      end
    end
    exp_rd  = !exc && (op != OP_SW);
    exp_wr  = !exc && ((op == OP_SW) || (op == OP_SB));
    wr_cyc  = (op == OP_SB) ? 2 : 1;
    lat     = exc ? 1 : ((op == OP_SB) ? 3 : 2);
    dropped = (flush_cyc == 0);
    flushed = (flush_cyc >= 1) && (flush_cyc <= lat);
    if (!dropped && !flushed) begin
      e.pos = pos; e.data = exp_data; e.exc = exc; e.lat = lat;
      sb_q.push_back(e);
    end

    @(negedge clk);
    check_eq({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; in_op = op; in_base = base; in_offset = off;
    in_sdata = sdata; in_iq_pos = pos; vm_rdata = rdata;
    flush_mask = dropped ? (8'h1 << pos) : 8'h0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush_mask = 8'h0;

    if (dropped) begin
      #1;
      check_eq({tag, "_drop_rdy"}, in_ready, 1'b1);
      check_eq({tag, "_drop_strb"}, {vm_read_en, vm_write_en, fin_valid}, 3'b000);
      return;
    end

    rd_seen = 0; wr_seen = 0; fin_seen = 0; ended = 0; hold_cnt = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (flush_cyc == cyc) flush_mask = 8'h1 << pos;
      fin_ready = (hold_cnt < hold) ? 1'b0 : 1'b1;
      #1;
      if (vm_read_en) begin
        rd_seen = 1;
        check_eq({tag, "_rd_cyc"}, cyc, 1);
        check_eq({tag, "_rd_addr"}, vm_addr, ea[17:2]);
      end
      if (vm_write_en) begin
        wr_seen = 1;
        check_eq({tag, "_wr_cyc"}, cyc, wr_cyc);
        check_eq({tag, "_wr_addr"}, vm_addr, ea[17:2]);
        check_eq({tag, "_wr_pos"}, vm_iq_pos, pos);
        check_eq({tag, "_wdata"}, vm_wdata, exp_wdata);
      end
      if (fin_valid) begin
        if (!fin_seen) begin
          fin_seen = 1;
          if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_underflow"}, 1, 0);
            got.pos = 0; got.data = 0; got.exc = 0; got.lat = 0;
          end else begin
            got = sb_q.pop_front();
          end
          check_eq({tag, "_lat"}, cyc, got.lat);
        end
        check_eq({tag, "_fin_data"}, fin_data, got.data);
        check_eq({tag, "_fin_exc"}, fin_exc, got.exc);
        check_eq({tag, "_fin_pos"}, fin_iq_pos, got.pos);
        if (!fin_ready) begin
          check_eq({tag, "_hold_rdy"}, in_ready, 1'b0);
          hold_cnt++;
        end else begin
          ended = 1;
        end
      end
      if (flush_cyc == cyc) ended = 1;
      @(posedge clk); #1;
      flush_mask = 8'h0; fin_ready = 1'b1;
      if (ended) begin
        #1;
        check_eq({tag, "_rdy_after"}, in_ready, 1'b1);
        break;
      end
    end
    if (!ended) check_eq({tag, "_timeout"}, 1, 0);
    check_eq({tag, "_rd_seen"}, rd_seen, exp_rd);
    check_eq({tag, "_wr_seen"}, wr_seen, exp_wr && !(flushed && flush_cyc <= wr_cyc));
    check_eq({tag, "_fin_seen"}, fin_seen, !flushed);
  endtask

  initial begin
    #12;
    check_eq("rst_rdy", in_ready, 1'b1);
    check_eq("rst_strb", {vm_read_en, vm_write_en, fin_valid, fin_exc}, 4'b0000);
    check_eq("rst_fin_data", fin_data, 32'h0);
    @(negedge clk); rst = 1'b0;

    run_op("lw",     OP_LW,  32'h100, 16'd4,    32'h0,        3'd1, 32'hCAFEF00D, 99, 0);
    run_op("sw",     OP_SW,  32'h20,  16'hFFFC, 32'h12345678, 3'd5, 32'h0,        99, 0);
    run_op("sb",     OP_SB,  32'h40,  16'd2,    32'h000000AB, 3'd2, 32'h11223344, 99, 0);
    run_op("lb",     OP_LB,  32'h40,  16'd2,    32'h0,        3'd3, 32'h11803344, 99, 0);
    run_op("lbu",    OP_LBU, 32'h40,  16'd2,    32'h0,        3'd4, 32'h11803344, 99, 0);
    run_op("lb_b3",  OP_LB,  32'h41,  16'd2,    32'h0,        3'd0, 32'h7F000000, 99, 0);
    run_op("sb_b0",  OP_SB,  32'h1000, 16'd0,   32'h5A5A5A5C, 3'd6, 32'hFFFFFFFF, 99, 0);
    run_op("lw_mis", OP_LW,  32'h100, 16'd2,    32'h0,        3'd7, 32'h0,        99, 0);
    run_op("sw_oor", OP_SW,  32'h40000, 16'd0,  32'h1,        3'd1, 32'h0,        99, 0);
    run_op("lw_neg", OP_LW,  32'h0,   16'hFFFC, 32'h0,        3'd2, 32'h0,        99, 0);
    run_op("lw_top", OP_LW,  32'h3FFF0, 16'hC,  32'h0,        3'd3, 32'h89ABCDEF, 99, 0);
    run_op("ill_op", 3'd7,   32'h100, 16'd0,    32'h0,        3'd4, 32'h0,        99, 0);
    run_op("drop",   OP_LW,  32'h100, 16'd0,    32'h0,        3'd5, 32'h1,        0,  0);
    run_op("fl_rd",  OP_LW,  32'h200, 16'd0,    32'h0,        3'd6, 32'h2,        1,  0);
    run_op("fl_sb",  OP_SB,  32'h200, 16'd1,    32'hCC,       3'd7, 32'h3,        1,  0);
    run_op("fl_dn",  OP_LW,  32'h300, 16'd0,    32'h0,        3'd0, 32'h4,        2,  0);
    run_op("fl_wr",  OP_SW,  32'h300, 16'd4,    32'h55,       3'd1, 32'h0,        1,  0);
    run_op("hold",   OP_LW,  32'h400, 16'd8,    32'h0,        3'd2, 32'hA5A50F0F, 99, 4);
    run_op("hold_x", OP_LW,  32'h401, 16'd0,    32'h0,        3'd3, 32'h0,        99, 2);

    // Reset pulse while a word store sits in WR.
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_SW; in_base = 32'h500; in_offset = 16'd0;
    in_sdata = 32'hDEADBEEF; in_iq_pos = 3'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("rstwr_pre", vm_write_en, 1'b1);
    rst = 1'b1; #1;
    check_eq("rstwr_rdy", in_ready, 1'b1);
    check_eq("rstwr_strb", {vm_read_en, vm_write_en, fin_valid, fin_exc}, 4'b0000);
    check_eq("rstwr_data", fin_data, 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rstwr_post", {in_ready, vm_write_en, fin_valid}, 3'b100);
    end

    run_op("lw_again", OP_LW, 32'h100, 16'd4, 32'h0, 3'd1, 32'h600DF00D, 99, 0);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
